// File: rtl/inst_fetcher_pkg.sv
// rtl/inst_fetcher_pkg.sv - shared types and helpers for the instruction fetch stage
package inst_fetcher_pkg;

    typedef enum logic [1:0] {
        IF_REQ  = 2'd0,
        IF_WAIT = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic inst_is_compressed(input logic [31:0] x);
        return x[1:0] != 2'b11;
    endfunction

    // Compressed instructions occupy only the low halfword; the upper half belongs to the next one.
    function automatic logic [31:0] inst_norm(input logic [31:0] x);
        return inst_is_compressed(x) ? {16'h0000, x[15:0]} : x;
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// rtl/inst_fetcher_if.sv - icache, decoder and ROB signals of the fetch stage
interface inst_fetcher_if;

    logic        wrong_predicted;
    logic [31:0] correct_pc;
    logic        issue_signal;
    logic [31:0] next_pc;
    logic        start_decode;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid;
    logic [31:0] icache_inst;

    modport master (
        input  wrong_predicted, correct_pc, issue_signal, next_pc, icache_valid, icache_inst,
        output start_decode, inst, inst_addr, icache_req, icache_addr
    );

    modport slave (
        output wrong_predicted, correct_pc, issue_signal, next_pc, icache_valid, icache_inst,
        input  start_decode, inst, inst_addr, icache_req, icache_addr
    );

endinterface

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - fetch PC owner: one icache request at a time, one instruction to decode
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    inst_fetcher_if.master bus
);

    if_state_e   state;
    logic [31:0] pc;
    logic        discard;
    logic        start_decode;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic [31:0] flush_pc;

    assign flush_pc         = bus.correct_pc & ~32'd1;
    assign bus.icache_req   = (state == IF_REQ) && rdy_in && !rst_in;
    assign bus.icache_addr  = pc;
    assign bus.start_decode = start_decode;
    assign bus.inst         = inst;
    assign bus.inst_addr    = inst_addr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IF_REQ;
            pc           <= RESET_PC & ~32'd1;
            discard      <= 1'b0;
            start_decode <= 1'b0;
            inst         <= 32'd0;
            inst_addr    <= 32'd0;
        end else if (rdy_in) begin
            case (state)
                IF_REQ: begin
                    state <= IF_WAIT;
                    // The pulse this cycle carried the old pc, so its response must be dropped.
                    if (bus.wrong_predicted) begin
                        pc      <= flush_pc;
                        discard <= 1'b1;
                    end
                end
                IF_WAIT: begin
                    if (bus.icache_valid) begin
                        if (discard || bus.wrong_predicted) begin
                            discard <= 1'b0;
                            if (bus.wrong_predicted) pc <= flush_pc;
                            state <= IF_REQ;
                        end else begin
                            inst         <= inst_norm(bus.icache_inst);
                            inst_addr    <= pc;
                            start_decode <= 1'b1;
                            state        <= IF_HOLD;
                        end
                    end else if (bus.wrong_predicted) begin
                        pc      <= flush_pc;
                        discard <= 1'b1;
                    end
                end
                IF_HOLD: begin
                    // A flush outranks a same-cycle issue: the issued instruction is on the wrong path.
                    if (bus.wrong_predicted) begin
                        pc           <= flush_pc;
                        start_decode <= 1'b0;
                        state        <= IF_REQ;
                    end else if (bus.issue_signal) begin
                        pc           <= bus.next_pc & ~32'd1;
                        start_decode <= 1'b0;
                        state        <= IF_REQ;
                    end
                end
                default: state <= IF_REQ;
            endcase
        end
    end

endmodule
